chopper_timers: RTL and testbench
=================================

CHOPPER_TIMERS -- requirements
Module: chopper_timers

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have ports offtimer_en0 and offtimer_en1, input, 1 bit each: per-channel off-time start request from the microstepper control stage.
REQ-004 SHALL have port phase_ct, input, 8 bits: microstep phase count; any change retriggers blanking.
REQ-005 SHALL have port config_offtime, input, 10 bits: off-timer load value, in ticks.
REQ-006 SHALL have port config_blanktime, input, 8 bits: blank-timer load value, in ticks.
REQ-007 SHALL have port config_minimum_on_time, input, 8 bits: minimum-on-timer load value, in ticks.
REQ-008 SHALL have port config_prescale, input, 4 bits: tick divider; one tick every config_prescale+1 clocks.
REQ-009 SHALL have ports off_timer0 and off_timer1, output, 10 bits each: current off-timer values.
REQ-010 SHALL have ports blank_timer0 and blank_timer1, output, 8 bits each: current blank-timer values.
REQ-011 SHALL have ports minimum_on_timer0 and minimum_on_timer1, output, 8 bits each: current minimum-on-timer values.

Function
REQ-012 SHALL keep a 4-bit prescale counter: tick=1 when counter==config_prescale, with counter cleared to 0 on tick and incremented otherwise; counter above config_prescale SHALL clear to 0 with tick=0.
REQ-013 SHALL, when offtimer_enN=1 and off_timerN==0, load off_timerN with config_offtime on the same edge, regardless of tick.
REQ-014 SHALL ignore offtimer_enN while off_timerN!=0.
REQ-015 SHALL treat a config_offtime of 0 at the start request as no load: off_timerN stays 0, and blank_timerN and minimum_on_timerN are not reloaded.
REQ-016 SHALL decrement each nonzero timer by 1 on tick only, saturating at 0.
REQ-017 SHALL, on the tick where off_timerN goes 1->0, load blank_timerN with config_blanktime and minimum_on_timerN with config_minimum_on_time on that edge.
REQ-018 SHALL give a load priority over a decrement of the same register in the same cycle.
REQ-019 SHALL NOT alter minimum_on_timerN on a start request; it keeps counting, so the downstream fault check sees overlap.
REQ-020 SHALL register phase_ct every cycle, including during reset, into phase_q; retrigger = resetn && (phase_ct != phase_q).
REQ-021 SHALL, on retrigger, load blank_timerN with config_blanktime for each channel whose off_timerN==0 and offtimer_enN==0; other channels are unaffected.
REQ-022 SHALL load blank_timerN once with config_blanktime when off-timer expiry and retrigger coincide.
REQ-023 SHALL keep channels 0 and 1 fully independent except for the shared prescaler, config inputs and retrigger.
REQ-024 SHALL let config changes affect only subsequent loads, never a value already in a timer.

Reset
REQ-025 SHALL, while resetn=0 at a clock edge, clear all six timer outputs and the prescale counter to 0.
REQ-026 SHALL NOT produce a retrigger on the first cycle after reset release, because phase_q is tracked during reset.
REQ-027 SHALL discard any in-progress off, blank or minimum-on interval when reset is applied mid-operation, with no expiry load on release.

Verification
REQ-028 SHALL cover basic chop: prescale=0, offtime=10, blank=5, min_on=8, pulse offtimer_en0 in cycle 0 -> off_timer0=10 at cycle 1, 0 at cycle 11 with blank_timer0=5 and minimum_on_timer0=8 at cycle 11, blank_timer0=0 at cycle 16, minimum_on_timer0=0 at cycle 19; channel 1 stays 0.
REQ-029 SHALL cover prescale: prescale=3, offtime=2 -> off_timer0 decrements only on ticks exactly 4 clocks apart, reaching 0 after 2 ticks, then blank loads.
REQ-030 SHALL cover retrigger: off timers 0, blank=6, phase_ct 0x10->0x11 -> blank_timer0=blank_timer1=6 next cycle; repeating with off_timer1=3 -> only blank_timer0 loads.
REQ-031 SHALL cover ignored request: offtimer_en0 while off_timer0=4 with prescale=0 -> next value 3, no reload.
REQ-032 SHALL cover reset mid-operation: resetn=0 with off_timer0=7, blank_timer1=2 -> all outputs 0 next edge; after release with phase_ct held at 0x55 -> no retrigger.
REQ-033 SHALL cover zero-length and overlap cases: offtime=0 with both enables -> nothing loads; offtimer_en0 while minimum_on_timer0=3 -> off_timer0 loads and minimum_on_timer0 continues to 2.

Source files
------------

// File: rtl/chopper_timers_if.sv
// Control/status bundle for chopper_timers.
//   master: drives the start requests, phase count and configuration, and
//           observes the six timer values.
//   slave : receives the requests and configuration, and drives the timers.
// Signal names match the block's documented port names.
interface chopper_timers_if;
  logic       offtimer_en0;
  logic       offtimer_en1;
  logic [7:0] phase_ct;
  logic [9:0] config_offtime;
  logic [7:0] config_blanktime;
  logic [7:0] config_minimum_on_time;
  logic [3:0] config_prescale;
  logic [9:0] off_timer0;
  logic [9:0] off_timer1;
  logic [7:0] blank_timer0;
  logic [7:0] blank_timer1;
  logic [7:0] minimum_on_timer0;
  logic [7:0] minimum_on_timer1;

  modport master (
    output offtimer_en0, offtimer_en1, phase_ct,
           config_offtime, config_blanktime, config_minimum_on_time, config_prescale,
    input  off_timer0, off_timer1, blank_timer0, blank_timer1,
           minimum_on_timer0, minimum_on_timer1
  );

  modport slave (
    input  offtimer_en0, offtimer_en1, phase_ct,
           config_offtime, config_blanktime, config_minimum_on_time, config_prescale,
    output off_timer0, off_timer1, blank_timer0, blank_timer1,
           minimum_on_timer0, minimum_on_timer1
  );
endinterface

// File: rtl/chopper_timers.sv
// Two-channel chopper timing for a microstepping motor driver.
// Each channel has an off timer (started by offtimer_enN), and a blank and
// minimum-on timer that are loaded when the off interval expires. Blanking is
// also retriggered when the microstep phase count changes. All timers count
// down on a shared prescaled tick.
//   clk    : clock, rising edge
//   resetn : synchronous active-low reset
//   bus    : chopper_timers_if.slave (requests/config in, timer values out)
module chopper_timers (
  input  logic              clk,
  input  logic              resetn,
  chopper_timers_if.slave   bus
);

  logic [3:0] presc_q, presc_d;
  logic       tick;
  logic [7:0] phase_q;
  logic       retrigger;
  logic [1:0] en;

  logic [9:0] off_q   [2];
  logic [9:0] off_d   [2];
  logic [7:0] blank_q [2];
  logic [7:0] blank_d [2];
  logic [7:0] minon_q [2];
  logic [7:0] minon_d [2];

  assign en = {bus.offtimer_en1, bus.offtimer_en0};

  // Only a phase change seen while out of reset counts as a retrigger.
  assign retrigger = resetn && (bus.phase_ct != phase_q);

  // NOTE: phase_q is deliberately left out of reset so it tracks phase_ct
  // throughout reset; otherwise release would look like a phase change.
  always_ff @(posedge clk) begin
    phase_q <= bus.phase_ct;
  end

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    tick    = 1'b0;
    presc_d = presc_q + 4'd1;
    if (presc_q == bus.config_prescale) begin
      tick    = 1'b1;
      presc_d = 4'd0;
    end else if (presc_q > bus.config_prescale) begin
      // Prescale was lowered below the running count: restart without a tick.
      presc_d = 4'd0;
    end

    for (int ch = 0; ch < 2; ch++) begin
      off_d[ch]   = off_q[ch];
      blank_d[ch] = blank_q[ch];
      minon_d[ch] = minon_q[ch];

      // Off timer: a start only lands while idle and with a nonzero load.
      if (en[ch] && (off_q[ch] == 10'd0) && (bus.config_offtime != 10'd0))
        off_d[ch] = bus.config_offtime;
      else if (tick && (off_q[ch] != 10'd0))
        off_d[ch] = off_q[ch] - 10'd1;

      // Blank timer: expiry and retrigger share one load, which beats decrement.
      if ((tick && (off_q[ch] == 10'd1)) ||
          (retrigger && (off_q[ch] == 10'd0) && !en[ch]))
        blank_d[ch] = bus.config_blanktime;
      else if (tick && (blank_q[ch] != 8'd0))
        blank_d[ch] = blank_q[ch] - 8'd1;

      // Minimum-on timer: loaded on expiry only; a new start leaves it running.
      if (tick && (off_q[ch] == 10'd1))
        minon_d[ch] = bus.config_minimum_on_time;
      else if (tick && (minon_q[ch] != 8'd0))
        minon_d[ch] = minon_q[ch] - 8'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      presc_q <= 4'd0;
      for (int ch = 0; ch < 2; ch++) begin
        off_q[ch]   <= 10'd0;
        blank_q[ch] <= 8'd0;
        minon_q[ch] <= 8'd0;
      end
    end else begin
      presc_q <= presc_d;
      for (int ch = 0; ch < 2; ch++) begin
        off_q[ch]   <= off_d[ch];
        blank_q[ch] <= blank_d[ch];
        minon_q[ch] <= minon_d[ch];
      end
    end
  end

  assign bus.off_timer0        = off_q[0];
  assign bus.off_timer1        = off_q[1];
  assign bus.blank_timer0      = blank_q[0];
  assign bus.blank_timer1      = blank_q[1];
  assign bus.minimum_on_timer0 = minon_q[0];
  assign bus.minimum_on_timer1 = minon_q[1];

endmodule

// File: tb/tb_chopper_timers.sv
// Directed testbench for chopper_timers. Inputs change and outputs are
// sampled on the falling edge; expected values are hand-computed.
module tb_chopper_timers;

  logic clk;
  logic resetn;
  int   n_checks;
  int   n_errors;

  chopper_timers_if bus ();

  chopper_timers dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, returning on the following falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic check_ch1_idle(input string tag);
    check({tag, " off1"},   32'(bus.off_timer1),        32'd0);
    check({tag, " blank1"}, 32'(bus.blank_timer1),      32'd0);
    check({tag, " minon1"}, 32'(bus.minimum_on_timer1), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " off0"},   32'(bus.off_timer0),        32'd0);
    check({tag, " blank0"}, 32'(bus.blank_timer0),      32'd0);
    check({tag, " minon0"}, 32'(bus.minimum_on_timer0), 32'd0);
    check_ch1_idle(tag);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    resetn                     = 1'b0;
    bus.offtimer_en0           = 1'b0;
    bus.offtimer_en1           = 1'b0;
    bus.phase_ct               = 8'h00;
    bus.config_offtime         = 10'd10;
    bus.config_blanktime       = 8'd5;
    bus.config_minimum_on_time = 8'd8;
    bus.config_prescale        = 4'd0;

    // Reset state
    step(3);
    check_all_zero("reset");

    // Release with phase unchanged: no retrigger
    resetn = 1'b1;
    step(1);
    check_all_zero("release");

    // Basic chop, prescale 0
    bus.offtimer_en0 = 1'b1;
    step(1);
    bus.offtimer_en0 = 1'b0;
    check("chop c1 off0", 32'(bus.off_timer0), 32'd10);
    check_ch1_idle("chop c1");
    step(9);
    check("chop c10 off0", 32'(bus.off_timer0), 32'd1);
    check("chop c10 blank0", 32'(bus.blank_timer0), 32'd0);
    step(1);
    check("chop c11 off0", 32'(bus.off_timer0), 32'd0);
    check("chop c11 blank0", 32'(bus.blank_timer0), 32'd5);
    check("chop c11 minon0", 32'(bus.minimum_on_timer0), 32'd8);
    step(5);
    check("chop c16 blank0", 32'(bus.blank_timer0), 32'd0);
    check("chop c16 minon0", 32'(bus.minimum_on_timer0), 32'd3);
    step(3);
    check("chop c19 minon0", 32'(bus.minimum_on_timer0), 32'd0);
    check_ch1_idle("chop c19");

    // Ignored request while off timer is running
    bus.config_offtime = 10'd4;
    bus.offtimer_en0 = 1'b1;
    step(1);
    check("ign load off0", 32'(bus.off_timer0), 32'd4);
    step(1);
    bus.offtimer_en0 = 1'b0;
    check("ign no reload off0", 32'(bus.off_timer0), 32'd3);
    step(3);
    check("ign expire off0", 32'(bus.off_timer0), 32'd0);
    check("ign expire minon0", 32'(bus.minimum_on_timer0), 32'd8);

    // Overlap: start while minimum-on still counting
    step(5);
    check("ovl pre minon0", 32'(bus.minimum_on_timer0), 32'd3);
    bus.offtimer_en0 = 1'b1;
    step(1);
    bus.offtimer_en0 = 1'b0;
    check("ovl off0", 32'(bus.off_timer0), 32'd4);
    check("ovl minon0", 32'(bus.minimum_on_timer0), 32'd2);
    step(20);
    check_all_zero("ovl drained");

    // Zero offtime with both enables: nothing loads
    bus.config_offtime = 10'd0;
    bus.offtimer_en0 = 1'b1;
    bus.offtimer_en1 = 1'b1;
    step(2);
    bus.offtimer_en0 = 1'b0;
    bus.offtimer_en1 = 1'b0;
    check_all_zero("zero len");

    // Retrigger on phase change
    bus.config_blanktime = 8'd6;
    bus.phase_ct = 8'h10;
    step(7);
    check("rt settle blank0", 32'(bus.blank_timer0), 32'd0);
    bus.phase_ct = 8'h11;
    step(1);
    check("rt both blank0", 32'(bus.blank_timer0), 32'd6);
    check("rt both blank1", 32'(bus.blank_timer1), 32'd6);
    step(6);
    check("rt drained blank1", 32'(bus.blank_timer1), 32'd0);
    bus.config_offtime = 10'd3;
    bus.offtimer_en1 = 1'b1;
    step(1);
    bus.offtimer_en1 = 1'b0;
    check("rt setup off1", 32'(bus.off_timer1), 32'd3);
    bus.phase_ct = 8'h12;
    step(1);
    check("rt one blank0", 32'(bus.blank_timer0), 32'd6);
    check("rt one blank1", 32'(bus.blank_timer1), 32'd0);
    check("rt one off1", 32'(bus.off_timer1), 32'd2);
    step(20);
    check_all_zero("rt drained");

    // Prescale 3, offtime 2: ticks every 4 clocks
    bus.config_offtime = 10'd2;
    bus.config_prescale = 4'd3;
    bus.offtimer_en0 = 1'b1;
    step(1);
    bus.offtimer_en0 = 1'b0;
    check("psc e1 off0", 32'(bus.off_timer0), 32'd2);
    step(2);
    check("psc e3 off0", 32'(bus.off_timer0), 32'd2);
    step(1);
    check("psc e4 off0", 32'(bus.off_timer0), 32'd1);
    step(3);
    check("psc e7 off0", 32'(bus.off_timer0), 32'd1);
    check("psc e7 blank0", 32'(bus.blank_timer0), 32'd0);
    step(1);
    check("psc e8 off0", 32'(bus.off_timer0), 32'd0);
    check("psc e8 blank0", 32'(bus.blank_timer0), 32'd6);
    check("psc e8 minon0", 32'(bus.minimum_on_timer0), 32'd8);
    step(1);
    check("psc e9 blank0", 32'(bus.blank_timer0), 32'd6);
    step(3);
    check("psc e12 blank0", 32'(bus.blank_timer0), 32'd5);

    // Reset mid-operation
    bus.config_prescale = 4'd0;
    step(40);
    check_all_zero("mid drained");
    bus.config_offtime = 10'd7;
    bus.config_blanktime = 8'd2;
    bus.offtimer_en0 = 1'b1;
    bus.phase_ct = 8'h20;
    step(1);
    bus.offtimer_en0 = 1'b0;
    check("mid setup off0", 32'(bus.off_timer0), 32'd7);
    check("mid setup blank0", 32'(bus.blank_timer0), 32'd0);
    check("mid setup blank1", 32'(bus.blank_timer1), 32'd2);
    resetn = 1'b0;
    bus.phase_ct = 8'h55;
    step(1);
    check_all_zero("mid reset");
    resetn = 1'b1;
    step(1);
    check_all_zero("mid release");
    step(8);
    check_all_zero("mid no expiry");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
